// File: rtl/snake_dir_ctrl_pkg.sv
// snake_pkg: shared encodings for the snake direction controller.
// Holds direction/press codes, FSM state type and small helpers.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [1:0] PRESS_NONE  = 2'd0;
   localparam logic [1:0] PRESS_SHORT = 2'd1;
   localparam logic [1:0] PRESS_LONG  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSED
   } state_e;

   function automatic logic [1:0] reverse_dir(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction

   // code 3 is not a press
   function automatic logic is_press(input logic [1:0] c);
      return (c == PRESS_SHORT) || (c == PRESS_LONG);
   endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: bundle between press classifiers / engine and
// the direction controller. master drives codes, tick, game_over.
interface snake_dir_ctrl_if #(
   parameter int QUEUE_DEPTH = 2
) ();
   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   logic [1:0]    code_up;
   logic [1:0]    code_down;
   logic [1:0]    code_left;
   logic [1:0]    code_right;
   logic          tick;
   logic          game_over;
   logic [1:0]    dir;
   logic          step;
   logic          paused;
   logic          running;
   logic [CW-1:0] q_count;

   modport master (
      output code_up, code_down, code_left, code_right,
      output tick, game_over,
      input  dir, step, paused, running, q_count
   );

   modport slave (
      input  code_up, code_down, code_left, code_right,
      input  tick, game_over,
      output dir, step, paused, running, q_count
   );
endinterface

// File: rtl/snake_dir_ctrl_dir_queue.sv
// dir_queue: circular FIFO of 2-bit turns with push/pop/flush.
// Ports: push, pop, flush, din -> head, tail, count, full, empty.
module dir_queue #(
   parameter  int DEPTH = 2,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [1:0]    din,
   output logic [1:0]    head,
   output logic [1:0]    tail,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULLC = CW'(DEPTH);

   logic [1:0]    mem [DEPTH];
   logic [PW-1:0] rd;
   logic [PW-1:0] wr;
   logic [PW-1:0] tl;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == FULLC);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot a full push needs
   assign do_push = push & (~full | do_pop);
   assign tl      = (wr == '0) ? LAST : wr - 1'b1;
   assign head    = mem[rd];
   assign tail    = mem[tl];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr] <= din;
            wr      <= nxt(wr);
         end
         if (do_pop) rd <= nxt(rd);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: press codes -> snake direction, step, run/pause.
// Ports: clk, rst (async high), bus (slave: codes/tick/game_over in).
module snake_dir_ctrl
   import snake_pkg::*;
#(
   parameter int         QUEUE_DEPTH = 2,
   parameter logic [1:0] INIT_DIR    = 2'd3
) (
   input logic              clk,
   input logic              rst,
   snake_dir_ctrl_if.slave  bus
);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   state_e        state;
   logic [1:0]    dir_q;
   logic          step_q;
   logic          paused_q;
   logic          running_q;

   logic [1:0]    sel_dir;
   logic          sel_short;
   logic          sel_long;
   logic [1:0]    last_dir;
   logic          go;
   logic          push;
   logic          pop;
   logic          legal;
   logic [1:0]    q_head;
   logic [1:0]    q_tail;
   logic [CW-1:0] q_cnt;
   logic          q_full;
   logic          q_empty;
   logic [1:0]    codes [4];

   assign codes[0] = bus.code_up;
   assign codes[1] = bus.code_down;
   assign codes[2] = bus.code_left;
   assign codes[3] = bus.code_right;

   // scan low priority first so the highest priority press wins
   always_comb begin
      sel_dir   = DIR_UP;
      sel_short = 1'b0;
      sel_long  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (is_press(codes[i])) begin
            sel_dir   = 2'(i);
            sel_short = (codes[i] == PRESS_SHORT);
            sel_long  = (codes[i] == PRESS_LONG);
         end
      end
   end

   always_comb begin
      last_dir = q_empty ? dir_q : q_tail;
      go       = bus.game_over && (state != ST_IDLE);
      pop      = !go && (state == ST_RUN) && bus.tick && !q_empty;
      legal    = sel_short
               && (sel_dir != last_dir)
               && (sel_dir != reverse_dir(last_dir))
               && (!q_full || pop);
      push     = !go && legal
               && ((state == ST_IDLE) || (state == ST_RUN));
   end

   dir_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (go),
      .din   (sel_dir),
      .head  (q_head),
      .tail  (q_tail),
      .count (q_cnt),
      .full  (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         dir_q     <= INIT_DIR;
         step_q    <= 1'b0;
         paused_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         step_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (push) begin
                  state     <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (go) begin
                  state     <= ST_IDLE;
                  dir_q     <= INIT_DIR;
                  running_q <= 1'b0;
               end else begin
                  if (bus.tick) step_q <= 1'b1;
                  if (pop) dir_q <= q_head;
                  if (sel_long) begin
                     state    <= ST_PAUSED;
                     paused_q <= 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (go) begin
                  state     <= ST_IDLE;
                  dir_q     <= INIT_DIR;
                  paused_q  <= 1'b0;
                  running_q <= 1'b0;
               end else if (sel_long) begin
                  state    <= ST_RUN;
                  paused_q <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               dir_q     <= INIT_DIR;
               paused_q  <= 1'b0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dir     = dir_q;
   assign bus.step    = step_q;
   assign bus.paused  = paused_q;
   assign bus.running = running_q;
   assign bus.q_count = q_cnt;
endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Converts the four per-button press codes produced by the press-classification stage into the snake's movement direction and game run/pause state. Short presses queue direction turns; the game tick consumes them. Long presses toggle pause. Sits between the four press classifiers and the snake body/movement engine, which consumes `dir` and `step`.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 2: pending-turn buffer depth; legal range 1..4.
- `INIT_DIR`, default 2'd3 (RIGHT): direction loaded at reset and on game over.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `code_up`, `code_down`, `code_left`, `code_right` in 2 each: press codes. 0 = none, 1 = short, 2 = long, 3 = treated as none. Each nonzero code is a single-cycle pulse.
- `tick` in 1: game-speed strobe, one cycle wide.
- `game_over` in 1: level or pulse from the movement engine.
- `dir` out 2: current direction. UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3.
- `step` out 1: one-cycle move strobe to the movement engine.
- `paused` out 1: high in PAUSED.
- `running` out 1: high in RUN or PAUSED.
- `q_count` out $clog2(QUEUE_DEPTH+1): pending turns.

## Operation
- States are IDLE, RUN and PAUSED.
- Reset values: state = IDLE, `dir` = INIT_DIR, `step` = 0, `paused` = 0, `running` = 0, queue empty, `q_count` = 0.
- Same-cycle arbitration: only one press is accepted per cycle. Priority is up > down > left > right, and long outranks short within each button. Lower-priority presses in that cycle are dropped.
- Reverse of direction d is d ^ 2'b01.
- Reference direction `last_dir` is the queue tail if the queue is non-empty, otherwise `dir`.
- Short press on d is enqueued only if all of these hold:
  - the state allows it (see below);
  - d != `last_dir`;
  - d != reverse(`last_dir`);
  - the queue is not full.
- A short press that fails any of these is silently dropped.
- IDLE:
  - A short press that passes the enqueue check enqueues and moves the state to RUN.
  - Long presses and ticks are ignored.
- RUN:
  - Short presses enqueue per the check above.
  - A long press moves the state to PAUSED.
  - On `tick`: if the queue is non-empty, pop the head into `dir`. In all cases, pulse `step` the next cycle.
- PAUSED:
  - `tick` and short presses are ignored; the queue contents are preserved.
  - A long press moves the state to RUN.
- `game_over` high in RUN or PAUSED:
  - next state IDLE, queue flushed, `dir` = INIT_DIR, and no `step` is generated.
  - `game_over` has priority over every other same-cycle event.
  - In IDLE it is ignored.
- Tick and enqueue in the same cycle:
  - The check uses pre-tick `last_dir`.
  - Pop and push both occur, so `q_count` is unchanged.
  - When the queue is full, the pop frees a slot and the push is accepted.

## Timing
- Press in cycle N: queue and `q_count` update at N+1. State change (IDLE→RUN, RUN↔PAUSED) is visible at N+1.
- Tick in cycle M (RUN): `dir` and `step` are valid at M+1. `step` is high for exactly one cycle.
- Tick and long press in the same cycle in RUN: the tick is processed (step at M+1), then the state becomes PAUSED.
- Tick in the same cycle as the IDLE→RUN press: ignored, because the state is still IDLE.
- Asserting `rst` mid-operation: all outputs go to their reset values immediately. No partial queue state survives.

## Structure
- `snake_pkg` holds:
  - direction encodings DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT;
  - press codes PRESS_NONE, PRESS_SHORT, PRESS_LONG;
  - the state encoding;
  - a `reverse_dir` function.
- Sub-module `dir_queue`: a parameterised circular FIFO of 2-bit entries. It supports simultaneous push/pop and flush, and exposes `head`, `tail`, `count`, `full` and `empty`.
- The FSM, arbitration and legality check stay in the top module.

## Test plan
- After reset: `dir`=3, `running`=0. Short `code_left`: dropped (reverse), `q_count`=0. Short `code_up`: RUN, `q_count`=1. Tick: `dir`=0 and `step`=1 the next cycle, `q_count`=0.
- In RUN with `dir`=UP: short up (dropped), short down (dropped), short left, short right (dropped, reverse of tail), short down. Then `q_count`=2. Three ticks give `dir` = 2, 1, 1.
- Queue full (depth 2): tick and short press in the same cycle → new entry accepted, `q_count` stays 2.
- Long `code_right` in RUN → `paused`=1. Five ticks → no `step`, `dir` unchanged, queue intact. Long press again → `paused`=0 and the next tick steps.
- `code_up`=1 and `code_left`=2 in the same cycle → only the up short press is acted on.
- `game_over` while PAUSED with `q_count`=2 → IDLE, `dir`=3, `q_count`=0, `paused`=0, no `step`. `rst` pulsed mid-RUN → all outputs at reset values.
